// File: rtl/tsi_switch_core_pkg.sv
// -----------------------------------------------------------------------------
// tsi_switch_core_pkg
// Shared sizes and the control-word layout for the 32x32 time-slot
// interchange switch.
//   NUM_SLOTS   : time slots per frame (5-bit slot index)
//   NUM_STREAMS : serial streams, i.e. slot width in bits
//   CTRL_W      : control word width
//   ctrl_word_t : control word, {rsvd_hi[15:14], en[13], rsvd_mid[12:5], src[4:0]}
// -----------------------------------------------------------------------------
package tsi_switch_core_pkg;

   localparam int NUM_SLOTS    = 32;
   localparam int NUM_STREAMS  = 8;
   localparam int CTRL_W       = 16;
   localparam int SLOT_W       = $clog2(NUM_SLOTS);

   localparam int CTRL_EN_BIT  = 13;
   localparam int CTRL_SRC_MSB = 4;
   localparam int CTRL_SRC_LSB = 0;

   typedef logic [SLOT_W-1:0]      slot_idx_t;
   typedef logic [NUM_STREAMS-1:0] slot_data_t;

   // Field order mirrors the bit positions above: en sits at CTRL_EN_BIT,
   // src occupies [CTRL_SRC_MSB:CTRL_SRC_LSB]. Reserved fields are stored
   // but never decoded.
   typedef struct packed {
      logic [1:0] rsvd_hi;   // [15:14]
      logic       en;        // [13]
      logic [7:0] rsvd_mid;  // [12:5]
      slot_idx_t  src;       // [4:0]
   } ctrl_word_t;

endpackage

// File: rtl/tsi_frame_buffer.sv
// -----------------------------------------------------------------------------
// tsi_frame_buffer
// Ping-pong 2 x 32 x 8 frame store. Incoming slots are written into the
// write bank; the other bank holds the previous complete frame and is read
// combinationally. The write bank toggles after the last slot of a frame,
// and frame_ready_o rises once the first complete frame has been stored.
//   clk_i         : clock, rising edge
//   reset_i       : synchronous, active-high
//   wr_en_i       : write the current slot
//   wr_addr_i     : slot index being written
//   wr_data_i     : slot byte
//   rd_addr_i     : slot index to read from the completed frame
//   rd_data_o     : slot byte from the completed frame (combinational)
//   frame_ready_o : at least one complete frame is stored
// -----------------------------------------------------------------------------
module tsi_frame_buffer
   import tsi_switch_core_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   wr_en_i,
   input  logic [SLOT_W-1:0]      wr_addr_i,
   input  logic [NUM_STREAMS-1:0] wr_data_i,
   input  logic [SLOT_W-1:0]      rd_addr_i,
   output logic [NUM_STREAMS-1:0] rd_data_o,
   output logic                   frame_ready_o
);

   slot_data_t mem_q [2][NUM_SLOTS];

   logic wr_bank_q,     wr_bank_d;
   logic frame_ready_q, frame_ready_d;
   logic frame_end;

   assign frame_end = wr_en_i && (wr_addr_i == slot_idx_t'(NUM_SLOTS - 1));

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_bank_d     = wr_bank_q;
      frame_ready_d = frame_ready_q;
      if (frame_end) begin
         wr_bank_d     = ~wr_bank_q;
         frame_ready_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_bank_q     <= 1'b0;
         frame_ready_q <= 1'b0;
      end else begin
         wr_bank_q     <= wr_bank_d;
         frame_ready_q <= frame_ready_d;
      end
   end

   // NOTE: the data RAM has no reset; it is only ever read after frame_ready
   // proves a full frame was written, and leaving it unreset lets it map to RAM.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_bank_q][wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o     = mem_q[~wr_bank_q][rd_addr_i];
   assign frame_ready_o = frame_ready_q;

endmodule

// File: rtl/tsi_switch_core.sv
// -----------------------------------------------------------------------------
// tsi_switch_core
// 32x32 time-slot interchange with 8-bit slots. Each valid cycle carries one
// slot (stream_in_j is bit j-1). Frames are stored in a ping-pong buffer and
// replayed one frame later, with each output slot k taking the input slot
// selected by control entry k (if its enable bit is set).
//   clk            : clock, rising edge
//   reset          : synchronous, active-high
//   input_valid    : current cycle carries a valid slot
//   control_write  : write control_data into entry control_addr
//   control_addr   : output slot index to program
//   control_data   : control word ({.., en[13], .., src[4:0]})
//   stream_in_1..8 : serial input bits, slot bits 0..7
//   stream_out_1..8: serial output bits, slot bits 0..7 (registered)
// -----------------------------------------------------------------------------
module tsi_switch_core
   import tsi_switch_core_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              input_valid,
   input  logic              control_write,
   input  logic [SLOT_W-1:0] control_addr,
   input  logic [CTRL_W-1:0] control_data,
   input  logic              stream_in_1,
   input  logic              stream_in_2,
   input  logic              stream_in_3,
   input  logic              stream_in_4,
   input  logic              stream_in_5,
   input  logic              stream_in_6,
   input  logic              stream_in_7,
   input  logic              stream_in_8,
   output logic              stream_out_1,
   output logic              stream_out_2,
   output logic              stream_out_3,
   output logic              stream_out_4,
   output logic              stream_out_5,
   output logic              stream_out_6,
   output logic              stream_out_7,
   output logic              stream_out_8
);

   ctrl_word_t ctrl_mem_q [NUM_SLOTS];
   slot_idx_t  slot_cnt_q, slot_cnt_d;
   slot_data_t out_q,      out_d;

   slot_data_t slot_in;
   slot_data_t rd_data;
   logic       frame_ready;
   ctrl_word_t cur_ctrl;
   logic       ctrl_unused;

   assign slot_in = {stream_in_8, stream_in_7, stream_in_6, stream_in_5,
                     stream_in_4, stream_in_3, stream_in_2, stream_in_1};

   // The entry for the current slot is read before this edge's control write
   // lands, so a same-cycle write to entry k affects only later reads of k.
   assign cur_ctrl = ctrl_mem_q[slot_cnt_q];

   // Reserved control bits are kept in the memory but never decoded.
   assign ctrl_unused = ^{cur_ctrl.rsvd_hi, cur_ctrl.rsvd_mid};

   tsi_frame_buffer u_frame_buffer (
      .clk_i         (clk),
      .reset_i       (reset),
      .wr_en_i       (input_valid),
      .wr_addr_i     (slot_cnt_q),
      .wr_data_i     (slot_in),
      .rd_addr_i     (cur_ctrl.src),
      .rd_data_o     (rd_data),
      .frame_ready_o (frame_ready)
   );

   // Output slot k is produced in lockstep with input slot k; the 5-bit
   // counter wraps from 31 to 0 on its own.
   always_comb begin
      slot_cnt_d = slot_cnt_q;
      out_d      = '0;
      if (input_valid) begin
         slot_cnt_d = slot_cnt_q + 1'b1;
         if (frame_ready && cur_ctrl.en) begin
            out_d = rd_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt_q <= '0;
         out_q      <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            ctrl_mem_q[i] <= '0;
         end
      end else begin
         slot_cnt_q <= slot_cnt_d;
         out_q      <= out_d;
         if (control_write) begin
            ctrl_mem_q[control_addr] <= ctrl_word_t'(control_data);
         end
      end
   end

   assign stream_out_1 = out_q[0];
   assign stream_out_2 = out_q[1];
   assign stream_out_3 = out_q[2];
   assign stream_out_4 = out_q[3];
   assign stream_out_5 = out_q[4];
   assign stream_out_6 = out_q[5];
   assign stream_out_7 = out_q[6];
   assign stream_out_8 = out_q[7];

endmodule

// File: tb/tb_tsi_switch_core.sv
// -----------------------------------------------------------------------------
// tb_tsi_switch_core
// Directed bench for tsi_switch_core. Inputs change 1 ns after each rising
// edge; the registered outputs are sampled at the same point, so the value
// seen after the edge that sampled input slot k is output slot k.
// -----------------------------------------------------------------------------
module tb_tsi_switch_core;

   typedef logic [7:0] frame_t [32];

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        input_valid = 1'b0;
   logic        control_write = 1'b0;
   logic [4:0]  control_addr = '0;
   logic [15:0] control_data = '0;
   logic        stream_in_1 = 1'b0, stream_in_2 = 1'b0, stream_in_3 = 1'b0, stream_in_4 = 1'b0;
   logic        stream_in_5 = 1'b0, stream_in_6 = 1'b0, stream_in_7 = 1'b0, stream_in_8 = 1'b0;
   logic        stream_out_1, stream_out_2, stream_out_3, stream_out_4;
   logic        stream_out_5, stream_out_6, stream_out_7, stream_out_8;
   logic [7:0]  out_bus;

   int n_cmp = 0;
   int n_err = 0;

   frame_t zero_f, pat_f, single_f, alt_f, inv_f, exp_f;
   logic [31:0] pats [8];

   always #5 clk = ~clk;

   assign out_bus = {stream_out_8, stream_out_7, stream_out_6, stream_out_5,
                     stream_out_4, stream_out_3, stream_out_2, stream_out_1};

   tsi_switch_core dut (
      .clk           (clk),
      .reset         (reset),
      .input_valid   (input_valid),
      .control_write (control_write),
      .control_addr  (control_addr),
      .control_data  (control_data),
      .stream_in_1   (stream_in_1),
      .stream_in_2   (stream_in_2),
      .stream_in_3   (stream_in_3),
      .stream_in_4   (stream_in_4),
      .stream_in_5   (stream_in_5),
      .stream_in_6   (stream_in_6),
      .stream_in_7   (stream_in_7),
      .stream_in_8   (stream_in_8),
      .stream_out_1  (stream_out_1),
      .stream_out_2  (stream_out_2),
      .stream_out_3  (stream_out_3),
      .stream_out_4  (stream_out_4),
      .stream_out_5  (stream_out_5),
      .stream_out_6  (stream_out_6),
      .stream_out_7  (stream_out_7),
      .stream_out_8  (stream_out_8)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic drive_in(input logic [7:0] b);
      {stream_in_8, stream_in_7, stream_in_6, stream_in_5,
       stream_in_4, stream_in_3, stream_in_2, stream_in_1} = b;
   endtask

   task automatic tick(input string tag, input logic [7:0] exp);
      @(posedge clk);
      #1;
      check(tag, out_bus, exp);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      input_valid   = 1'b0;
      control_write = 1'b0;
      for (int i = 0; i < n; i++) begin
         drive_in(8'($urandom));
         tick($sformatf("%s idle%0d", tag, i), 8'h00);
      end
   endtask

   task automatic wr_ctrl(input logic [4:0] a, input logic [15:0] d, input string tag);
      input_valid   = 1'b0;
      control_write = 1'b1;
      control_addr  = a;
      control_data  = d;
      tick($sformatf("%s wr%0d", tag, a), 8'h00);
      control_write = 1'b0;
   endtask

   // One full frame; optional 10-cycle gap before slot gap_at and optional
   // control write to entry wr_slot in the same cycle that slot is sampled.
   task automatic send_frame(input frame_t din, input frame_t exp, input int gap_at,
                             input int wr_slot, input logic [15:0] wr_word, input string tag);
      for (int i = 0; i < 32; i++) begin
         if (i == gap_at) idle_cycles(10, $sformatf("%s gap", tag));
         input_valid   = 1'b1;
         drive_in(din[i]);
         control_write = (i == wr_slot);
         control_addr  = 5'(i);
         control_data  = wr_word;
         tick($sformatf("%s slot%0d", tag, i), exp[i]);
      end
      input_valid   = 1'b0;
      control_write = 1'b0;
   endtask

   // Output slot k takes input slot (k+1)%32 of the previous frame.
   task automatic rotate(input frame_t f, output frame_t r);
      for (int k = 0; k < 32; k++) r[k] = f[(k + 1) % 32];
   endtask

   initial begin
      pats[0] = 32'h44332211; pats[1] = 32'h88776655;
      pats[2] = 32'hCCBBAA99; pats[3] = 32'h65FFEEDD;
      pats[4] = 32'hA1A2A3A4; pats[5] = 32'hB1B2B3B4;
      pats[6] = 32'hC1C2C3C4; pats[7] = 32'hD1D2D3D4;
      for (int i = 0; i < 32; i++) begin
         zero_f[i]   = 8'h00;
         single_f[i] = (i == 5) ? 8'h01 : 8'h00;
         alt_f[i]    = 8'(i * 37 + 5);
         for (int j = 0; j < 8; j++) pat_f[i][j] = pats[j][i];
         inv_f[i]    = ~pat_f[i];
      end

      // Reset held 3 cycles under random inputs.
      for (int i = 0; i < 3; i++) begin
         input_valid   = 1'($urandom);
         control_write = 1'($urandom);
         control_addr  = 5'($urandom);
         control_data  = 16'($urandom);
         drive_in(8'($urandom));
         tick($sformatf("reset%0d", i), 8'h00);
      end
      reset         = 1'b0;
      control_write = 1'b0;

      // No control programmed: first frame not ready, second frame all disabled.
      send_frame(pat_f, zero_f, -1, -1, 16'h0, "noctrl_f1");
      send_frame(pat_f, zero_f, -1, -1, 16'h0, "noctrl_f2");

      // Identity map.
      for (int k = 0; k < 32; k++) wr_ctrl(5'(k), 16'h2000 | 16'(k), "ident");
      send_frame(pat_f, pat_f, -1, -1, 16'h0, "ident_f1");
      send_frame(pat_f, pat_f, -1, -1, 16'h0, "ident_f2");

      // Single-bit permutation, disabled entry, upper bits ignored.
      for (int k = 0; k < 32; k++) wr_ctrl(5'(k), 16'h0000, "clear");
      wr_ctrl(5'd0, 16'h2005, "perm");
      wr_ctrl(5'd3, 16'h0005, "perm");
      wr_ctrl(5'd7, 16'hA005, "perm");
      exp_f = zero_f;
      exp_f[0] = pat_f[5];
      exp_f[7] = pat_f[5];
      send_frame(single_f, exp_f, -1, -1, 16'h0, "perm_f1");
      exp_f = zero_f;
      exp_f[0] = 8'h01;
      exp_f[7] = 8'h01;
      send_frame(single_f, exp_f, -1, -1, 16'h0, "perm_f2");

      // Rotation, programmed after idle.
      idle_cycles(5, "pre_rot");
      for (int k = 0; k < 32; k++) wr_ctrl(5'(k), 16'hA000 | 16'((k + 1) % 32), "rot");
      rotate(single_f, exp_f);
      send_frame(alt_f, exp_f, -1, -1, 16'h0, "rot_f1");
      rotate(alt_f, exp_f);
      send_frame(inv_f, exp_f, -1, -1, 16'h0, "rot_f2");

      // input_valid gap mid-frame.
      rotate(inv_f, exp_f);
      send_frame(pat_f, exp_f, 15, -1, 16'h0, "gap_f1");
      rotate(pat_f, exp_f);
      send_frame(alt_f, exp_f, -1, -1, 16'h0, "gap_f2");

      // Same-cycle write and read of entry 10: old entry used, new one next frame.
      rotate(alt_f, exp_f);
      send_frame(inv_f, exp_f, -1, 10, 16'h2000, "rw_f1");
      rotate(inv_f, exp_f);
      exp_f[10] = inv_f[0];
      send_frame(pat_f, exp_f, -1, -1, 16'h0, "rw_f2");

      // Reset mid-frame after 13 slots.
      rotate(pat_f, exp_f);
      exp_f[10] = pat_f[0];
      for (int i = 0; i < 13; i++) begin
         input_valid = 1'b1;
         drive_in(alt_f[i]);
         tick($sformatf("pre_rst slot%0d", i), exp_f[i]);
      end
      reset = 1'b1;
      tick("midreset", 8'h00);
      reset       = 1'b0;
      input_valid = 1'b0;
      send_frame(alt_f, zero_f, -1, -1, 16'h0, "post_rst_f1");
      send_frame(pat_f, zero_f, -1, -1, 16'h0, "post_rst_f2");
      for (int k = 0; k < 32; k++) wr_ctrl(5'(k), 16'h2000 | 16'(k), "ident2");
      send_frame(alt_f, pat_f, -1, -1, 16'h0, "post_rst_f3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
